// File: rtl/shifter_pkg.sv
// Shared op encodings, stage mode word and decode helpers for the pipelined shifter.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b010,
        OP_SRA = 3'b011,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } shift_op_e;

    // Per-operation control that travels with the data through every stage.
    typedef struct packed {
        logic err;   // illegal opcode; data forced to zero at entry
        logic rev;   // right-type op: operand and result are bit-reversed
        logic rot;   // rotate instead of fill
        logic fill;  // bit shifted into vacated positions
    } shift_mode_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic shift_mode_t decode_mode(input logic [2:0] op, input logic msb);
        shift_mode_t m;
        m      = '0;
        m.err  = !is_legal_op(op);
        m.rev  = (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
        m.rot  = (op == OP_ROL) || (op == OP_ROR);
        m.fill = (op == OP_SRA) && msb;
        return m;
    endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// Operation/result handshake bundle for pipe_shifter.
interface pipe_shifter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [2:0]            Shiftop;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Result;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_err;

    modport master (
        output flush, in_valid, A, B, Shiftop, in_tag, out_ready,
        input  in_ready, out_valid, Result, out_tag, out_err
    );

    modport slave (
        input  flush, in_valid, A, B, Shiftop, in_tag, out_ready,
        output in_ready, out_valid, Result, out_tag, out_err
    );
endinterface

// File: rtl/shift_stage.sv
// One pipeline stage: conditional left shift/rotate by 2**STAGE_IDX, then register.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned STAGE_IDX  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_advance,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  shift_mode_t           i_mode,
    input  logic [log2(DATA_WIDTH)-1:0] i_shamt,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output shift_mode_t           o_mode,
    output logic [log2(DATA_WIDTH)-1:0] o_shamt,
    output logic [TAG_WIDTH-1:0]  o_tag
);
    localparam int unsigned SHAMT_W = log2(DATA_WIDTH);
    localparam int unsigned SHIFT   = 32'd1 << STAGE_IDX;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    shift_mode_t           r_mode;
    logic [SHAMT_W-1:0]    r_shamt;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [DATA_WIDTH-1:0] w_shifted;

    always_comb begin
        w_shifted = {i_data[DATA_WIDTH-1-SHIFT:0], {SHIFT{i_mode.fill}}};
        if (i_mode.rot) begin
            w_shifted = {i_data[DATA_WIDTH-1-SHIFT:0], i_data[DATA_WIDTH-1:DATA_WIDTH-SHIFT]};
        end
    end

    // Flush outranks a stall: valid clears even when the stage is holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_mode  <= '0;
            r_shamt <= '0;
            r_tag   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_advance) begin
            r_valid <= i_valid;
            r_data  <= i_shamt[STAGE_IDX] ? w_shifted : i_data;
            r_mode  <= i_mode;
            r_shamt <= i_shamt;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_mode  = r_mode;
    assign o_shamt = r_shamt;
    assign o_tag   = r_tag;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: log2(DATA_WIDTH) stages, valid/ready flow control, tag sideband.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_shifter_if.slave bus
);
    localparam int unsigned SHAMT_W = log2(DATA_WIDTH);

    logic                  w_valid [SHAMT_W+1];
    logic [DATA_WIDTH-1:0] w_data  [SHAMT_W+1];
    shift_mode_t           w_mode  [SHAMT_W+1];
    logic [SHAMT_W-1:0]    w_shamt [SHAMT_W+1];
    logic [TAG_WIDTH-1:0]  w_tag   [SHAMT_W+1];

    logic                  w_advance;
    logic                  w_accept;
    shift_mode_t           w_entry_mode;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_unused_bits;

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            r[i] = v[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    assign w_advance    = !w_valid[SHAMT_W] || bus.out_ready;
    assign bus.in_ready = rst_n && !bus.flush && w_advance;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Right shifts and rotates reuse the left network: reverse on entry, reverse on exit.
    assign w_entry_mode = decode_mode(bus.Shiftop, bus.A[DATA_WIDTH-1]);
    assign w_valid[0]   = w_accept;
    assign w_mode[0]    = w_entry_mode;
    assign w_data[0]    = w_entry_mode.err ? '0 :
                          (w_entry_mode.rev ? bit_rev(bus.A) : bus.A);
    assign w_shamt[0]   = bus.B[SHAMT_W-1:0];
    assign w_tag[0]     = bus.in_tag;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .STAGE_IDX  (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_flush   (bus.flush),
            .i_advance (w_advance),
            .i_valid   (w_valid[k]),
            .i_data    (w_data[k]),
            .i_mode    (w_mode[k]),
            .i_shamt   (w_shamt[k]),
            .i_tag     (w_tag[k]),
            .o_valid   (w_valid[k+1]),
            .o_data    (w_data[k+1]),
            .o_mode    (w_mode[k+1]),
            .o_shamt   (w_shamt[k+1]),
            .o_tag     (w_tag[k+1])
        );
    end

    assign w_out_data    = w_mode[SHAMT_W].rev ? bit_rev(w_data[SHAMT_W]) : w_data[SHAMT_W];
    assign bus.out_valid = rst_n && w_valid[SHAMT_W];
    assign bus.Result    = rst_n ? w_out_data : '0;
    assign bus.out_tag   = rst_n ? w_tag[SHAMT_W] : '0;
    assign bus.out_err   = rst_n && w_valid[SHAMT_W] && w_mode[SHAMT_W].err;

    assign w_unused_bits = ^{bus.B[DATA_WIDTH-1:SHAMT_W], w_shamt[SHAMT_W],
                             w_mode[SHAMT_W].rot, w_mode[SHAMT_W].fill};

endmodule
